fadd_sched: RTL and testbench

FADD_SCHED -- requirements
Module: fadd_sched

---
 rtl/fadd_sched.sv | 120 ++++++++++++
 tb/tb_fadd_sched.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fadd_sched.sv
// Two-requester front end for a shared pipelined floating-point adder.
// Round-robin grant, per-requester credit limit, tagged in-order result return.
module fadd_sched #(
    parameter int LATENCY = 3,
    parameter int MAX_OUT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [31:0] a_op1,
    input  logic [31:0] a_op2,
    output logic        a_resp_valid,
    output logic [31:0] a_resp_result,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [31:0] b_op1,
    input  logic [31:0] b_op2,
    output logic        b_resp_valid,
    output logic [31:0] b_resp_result,
    output logic [31:0] fadd_op1,
    output logic [31:0] fadd_op2,
    input  logic [31:0] fadd_result,
    output logic        busy
);

    logic [2:0]       a_cnt_reg, a_cnt_next;
    logic [2:0]       b_cnt_reg, b_cnt_next;
    logic             last_grant_reg;          // 1 = B was granted last
    logic [31:0]      fadd_op1_reg, fadd_op2_reg;
    logic             a_resp_valid_reg, b_resp_valid_reg;
    logic [31:0]      a_resp_result_reg, b_resp_result_reg;
    // Stage 0 loads with the operand register; stage LATENCY lines up with fadd_result.
    logic [LATENCY:0] pipe_valid_reg;
    logic [LATENCY:0] pipe_tag_reg;            // 1 = result belongs to B

    logic a_elig, b_elig, a_grant, b_grant, accept;
    logic final_a, final_b;

    always_comb begin
        a_elig  = a_valid && (a_cnt_reg < 3'(MAX_OUT)) && !reset;
        b_elig  = b_valid && (b_cnt_reg < 3'(MAX_OUT)) && !reset;
        a_grant = a_elig && (!b_elig || last_grant_reg);
        b_grant = b_elig && !a_grant;
        accept  = a_grant || b_grant;
        final_a = pipe_valid_reg[LATENCY] && !pipe_tag_reg[LATENCY];
        final_b = pipe_valid_reg[LATENCY] &&  pipe_tag_reg[LATENCY];
    end

    // A response edge frees a credit; an accept on the same edge cancels it out.
    always_comb begin
        a_cnt_next = a_cnt_reg;
        if (a_grant && !a_resp_valid_reg)
            a_cnt_next = a_cnt_reg + 3'd1;
        else if (!a_grant && a_resp_valid_reg && a_cnt_reg != 3'd0)
            a_cnt_next = a_cnt_reg - 3'd1;
        b_cnt_next = b_cnt_reg;
        if (b_grant && !b_resp_valid_reg)
            b_cnt_next = b_cnt_reg + 3'd1;
        else if (!b_grant && b_resp_valid_reg && b_cnt_reg != 3'd0)
            b_cnt_next = b_cnt_reg - 3'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_cnt_reg         <= 3'd0;
            b_cnt_reg         <= 3'd0;
            last_grant_reg    <= 1'b1;
            fadd_op1_reg      <= 32'h0;
            fadd_op2_reg      <= 32'h0;
            a_resp_valid_reg  <= 1'b0;
            b_resp_valid_reg  <= 1'b0;
            a_resp_result_reg <= 32'h0;
            b_resp_result_reg <= 32'h0;
            pipe_valid_reg[0] <= 1'b0;
            pipe_tag_reg[0]   <= 1'b0;
        end else begin
            a_cnt_reg         <= a_cnt_next;
            b_cnt_reg         <= b_cnt_next;
            pipe_valid_reg[0] <= accept;
            pipe_tag_reg[0]   <= b_grant;
            if (accept) begin
                fadd_op1_reg   <= b_grant ? b_op1 : a_op1;
                fadd_op2_reg   <= b_grant ? b_op2 : a_op2;
                last_grant_reg <= b_grant;
            end
            a_resp_valid_reg <= final_a;
            b_resp_valid_reg <= final_b;
            if (final_a)
                a_resp_result_reg <= fadd_result;
            if (final_b)
                b_resp_result_reg <= fadd_result;
        end
    end

    generate
        for (genvar gi = 1; gi <= LATENCY; gi++) begin : g_stage
            always_ff @(posedge clk) begin
                if (reset) begin
                    pipe_valid_reg[gi] <= 1'b0;
                    pipe_tag_reg[gi]   <= 1'b0;
                end else begin
                    pipe_valid_reg[gi] <= pipe_valid_reg[gi-1];
                    pipe_tag_reg[gi]   <= pipe_tag_reg[gi-1];
                end
            end
        end
    endgenerate

    assign a_ready       = a_grant;
    assign b_ready       = b_grant;
    assign fadd_op1      = fadd_op1_reg;
    assign fadd_op2      = fadd_op2_reg;
    assign a_resp_valid  = a_resp_valid_reg;
    assign b_resp_valid  = b_resp_valid_reg;
    assign a_resp_result = a_resp_result_reg;
    assign b_resp_result = b_resp_result_reg;
    assign busy          = !reset && (|pipe_valid_reg || a_resp_valid_reg || b_resp_valid_reg);

endmodule

// File: tb/tb_fadd_sched.sv
// Bench for fadd_sched: transaction-level reference model checked every cycle,
// plus a vector table and directed multi-cycle sequences.
module tb_fadd_sched;

    localparam int L = 3;
    localparam int M = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [31:0] a_op1 = 32'h0, a_op2 = 32'h0, b_op1 = 32'h0, b_op2 = 32'h0;
    logic        a_ready, b_ready, a_resp_valid, b_resp_valid, busy;
    logic [31:0] a_resp_result, b_resp_result, fadd_op1, fadd_op2, fadd_result;

    fadd_sched #(.LATENCY(L), .MAX_OUT(M)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_op1(a_op1), .a_op2(a_op2),
        .a_resp_valid(a_resp_valid), .a_resp_result(a_resp_result),
        .b_valid(b_valid), .b_ready(b_ready), .b_op1(b_op1), .b_op2(b_op2),
        .b_resp_valid(b_resp_valid), .b_resp_result(b_resp_result),
        .fadd_op1(fadd_op1), .fadd_op2(fadd_op2), .fadd_result(fadd_result),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in adder: integer sum of the operands, L edges after they are registered.
    logic [31:0] fpipe [0:L-1];
    initial for (int i = 0; i < L; i++) fpipe[i] = 32'h0;
    always @(posedge clk) begin
        fpipe[0] <= fadd_op1 + fadd_op2;
        for (int i = 1; i < L; i++) fpipe[i] <= fpipe[i-1];
    end
    assign fadd_result = fpipe[L-1];

    typedef struct {
        logic        is_b;
        logic [31:0] res;
        int          due;
    } op_t;

    op_t         q[$];
    int          cyc_n = 0;
    int          total = 0;
    int          bad = 0;
    logic        lg_b = 1'b1;
    logic [31:0] last_a = 32'h0, last_b = 32'h0, exp_op1 = 32'h0, exp_op2 = 32'h0;
    logic        o_ar, o_br, o_arv, o_brv;
    logic [31:0] o_ares, o_bres, o_op1, o_op2;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc_n, act, exp);
        end
    endtask

    // One clock cycle: apply inputs, compare against the model mid-cycle, advance.
    task automatic cyc(input logic rst, input logic va, input logic vb,
                       input logic [31:0] a1, input logic [31:0] a2,
                       input logic [31:0] b1, input logic [31:0] b2);
        logic        ea, eb, xa, xb, ra, rb;
        int          oa, ob;
        logic [31:0] res;
        reset = rst; a_valid = va; b_valid = vb;
        a_op1 = a1; a_op2 = a2; b_op1 = b1; b_op2 = b2;
        @(negedge clk);
        while (q.size() > 0 && q[0].due < cyc_n) void'(q.pop_front());
        oa = 0; ob = 0;
        foreach (q[i]) if (q[i].is_b) ob++; else oa++;
        ra = 1'b0; rb = 1'b0; res = 32'h0;
        if (q.size() > 0 && q[0].due == cyc_n) begin
            ra = !q[0].is_b; rb = q[0].is_b; res = q[0].res;
        end
        if (ra) last_a = res;
        if (rb) last_b = res;
        ea = va && (oa < M) && !rst;
        eb = vb && (ob < M) && !rst;
        xa = ea && (!eb || lg_b);
        xb = eb && !xa;
        check("a_ready", a_ready, xa);
        check("b_ready", b_ready, xb);
        check("a_resp_valid", a_resp_valid, ra);
        check("b_resp_valid", b_resp_valid, rb);
        check("a_resp_result", a_resp_result, last_a);
        check("b_resp_result", b_resp_result, last_b);
        check("fadd_op1", fadd_op1, exp_op1);
        check("fadd_op2", fadd_op2, exp_op2);
        check("busy", busy, !rst && q.size() > 0);
        o_ar = a_ready; o_br = b_ready; o_arv = a_resp_valid; o_brv = b_resp_valid;
        o_ares = a_resp_result; o_bres = b_resp_result; o_op1 = fadd_op1; o_op2 = fadd_op2;
        if (rst) begin
            q.delete();
            lg_b = 1'b1; last_a = 32'h0; last_b = 32'h0; exp_op1 = 32'h0; exp_op2 = 32'h0;
        end else if (xa) begin
            q.push_back('{1'b0, a1 + a2, cyc_n + L + 2});
            lg_b = 1'b0; exp_op1 = a1; exp_op2 = a2;
        end else if (xb) begin
            q.push_back('{1'b1, b1 + b2, cyc_n + L + 2});
            lg_b = 1'b1; exp_op1 = b1; exp_op2 = b2;
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    typedef struct {
        logic        is_b;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] sum;
        int          lat;
    } vec_t;

    vec_t vt [4];

    initial begin
        int          lat, other;
        logic        got;
        logic [31:0] res;
        logic [3:0]  gseq;
        logic [12:0] rseq;

        vt[0] = '{1'b0, 32'h3F800000, 32'h40000000, 32'h7F800000, 5};
        vt[1] = '{1'b1, 32'h00000000, 32'h7F7FFFFF, 32'h7F7FFFFF, 5};
        vt[2] = '{1'b1, 32'h00800000, 32'h7E7FFFFF, 32'h7EFFFFFF, 5};
        vt[3] = '{1'b0, 32'h00000000, 32'h7F7FFFFF, 32'h7F7FFFFF, 5};

        @(posedge clk);
        #1;
        do_reset();
        check("reset_busy", busy, 1'b0);
        check("reset_op1", fadd_op1, 32'h0);

        // Single operations: grant, operand forwarding, latency, routing.
        for (int v = 0; v < 4; v++) begin
            do_reset();
            cyc(1'b0, !vt[v].is_b, vt[v].is_b, vt[v].op1, vt[v].op2, vt[v].op1, vt[v].op2);
            check("vec_grant", vt[v].is_b ? o_br : o_ar, 1'b1);
            got = 1'b0; lat = 0; other = 0; res = 32'h0;
            for (int t = 1; t <= 12; t++) begin
                idle();
                if (t == 1) begin
                    check("vec_op1", o_op1, vt[v].op1);
                    check("vec_op2", o_op2, vt[v].op2);
                end
                if ((vt[v].is_b ? o_brv : o_arv) && !got) begin
                    got = 1'b1; lat = t; res = vt[v].is_b ? o_bres : o_ares;
                end
                if (vt[v].is_b ? o_arv : o_brv) other++;
            end
            check("vec_latency", 32'(lat), 32'(vt[v].lat));
            check("vec_result", res, vt[v].sum);
            check("vec_other_resp", 32'(other), 32'h0);
        end

        // Both requesters held valid: grants alternate starting with A.
        do_reset();
        gseq = 4'h0;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 1'b1, $urandom, $urandom, $urandom, $urandom);
            if (i < 4) gseq[i] = o_br;
        end
        check("alt_grants", {28'h0, gseq}, 32'h0000000A);
        repeat (8) idle();

        // Only A held valid: credit limit, resume timing, accept coinciding with a response.
        do_reset();
        rseq = 13'h0;
        for (int i = 0; i < 13; i++) begin
            cyc(1'b0, 1'b1, 1'b0, $urandom, $urandom, 32'h0, 32'h0);
            rseq[i] = o_ar;
        end
        check("credit_ready_seq", {19'h0, rseq}, 32'h000010C3);
        repeat (8) idle();

        // Reset two cycles after an accept discards it; first tie then goes to A.
        do_reset();
        cyc(1'b0, 1'b1, 1'b0, 32'h11111111, 32'h22222222, 32'h0, 32'h0);
        idle();
        idle();
        do_reset();
        other = 0;
        for (int i = 0; i < 8; i++) begin
            idle();
            if (o_arv || o_brv) other++;
        end
        check("discard_resp", 32'(other), 32'h0);
        check("discard_busy", busy, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 32'h1, 32'h2, 32'h3, 32'h4);
        check("post_reset_tie", {o_ar, o_br}, 2'b10);
        repeat (8) idle();

        // Random traffic with occasional reset, checked by the model every cycle.
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 199) == 0,
                $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                $urandom, $urandom, $urandom, $urandom);
        end
        repeat (10) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
